// File: rtl/util_trafic_pkg.sv
// rtl/util_trafic_pkg.sv - shared FSM encoding and clog2 helper for the traffic arbiter
package util_trafic_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } arb_state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/util_trafic_arbiter_if.sv
// rtl/util_trafic_arbiter_if.sv - slave-side streams and merged master stream of the arbiter
interface util_trafic_arbiter_if #(
   parameter int NUM_SRC    = 4,
   parameter int TBYTE_NUM  = 16,
   parameter int ID_WIDTH   = 5,
   parameter int DEST_WIDTH = 5
);
   logic [NUM_SRC-1:0]             s_axis_tvalid;
   logic [NUM_SRC-1:0]             s_axis_tready;
   logic [NUM_SRC*TBYTE_NUM*8-1:0] s_axis_tdata;
   logic [NUM_SRC*TBYTE_NUM-1:0]   s_axis_tkeep;
   logic                           m_axis_tvalid;
   logic                           m_axis_tready;
   logic [TBYTE_NUM*8-1:0]         m_axis_tdata;
   logic [TBYTE_NUM-1:0]           m_axis_tkeep;
   logic                           m_axis_tlast;
   logic [ID_WIDTH-1:0]            m_axis_tid;
   logic [DEST_WIDTH-1:0]          m_axis_tdest;

   // master: the arbiter itself; slave: the generators and sink around it
   modport master (
      input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, m_axis_tready,
      output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep,
             m_axis_tlast, m_axis_tid, m_axis_tdest
   );

   modport slave (
      output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, m_axis_tready,
      input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep,
             m_axis_tlast, m_axis_tid, m_axis_tdest
   );

endinterface

// File: rtl/util_rr_pick.sv
// rtl/util_rr_pick.sv - combinational round-robin priority encoder
module util_rr_pick
   import util_trafic_pkg::*;
#(
   parameter int NUM_SRC = 4
) (
   input  logic [NUM_SRC-1:0]        i_req,
   input  logic [clog2(NUM_SRC)-1:0] i_ptr,
   output logic [clog2(NUM_SRC)-1:0] o_idx,
   output logic                      o_found
);
   localparam int IDX_W = clog2(NUM_SRC);

   logic [IDX_W-1:0] w_cand;
   int               w_pos;

   // Scan from farthest to nearest so the closest request at or above i_ptr wins.
   always_comb begin
      o_idx   = '0;
      o_found = 1'b0;
      w_cand  = '0;
      w_pos   = 0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         w_pos = int'(i_ptr) + k;
         if (w_pos >= NUM_SRC) begin
            w_pos = w_pos - NUM_SRC;
         end
         w_cand = IDX_W'(w_pos);
         if (i_req[w_cand]) begin
            o_idx   = w_cand;
            o_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/util_trafic_arbiter.sv
// rtl/util_trafic_arbiter.sv - round-robin AXIS burst arbiter; TRAFIC_ARB_STATS_EN adds per-source beat counters
module util_trafic_arbiter
   import util_trafic_pkg::*;
#(
   parameter int NUM_SRC    = 4,
   parameter int TBYTE_NUM  = 16,
   parameter int ID_WIDTH   = 5,
   parameter int DEST_WIDTH = 5,
   parameter int BURST_LEN  = 64,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic [NUM_SRC-1:0]            src_mask,
   util_trafic_arbiter_if.master         axis,
   output logic                          busy,
   output logic [clog2(NUM_SRC)-1:0]     grant_idx,
   output logic [NUM_SRC*CNT_WIDTH-1:0]  beat_cnt
);
   localparam int IDX_W  = clog2(NUM_SRC);
   localparam int BEAT_W = clog2(BURST_LEN + 1);
   localparam int DATA_W = TBYTE_NUM * 8;

   arb_state_t        r_state;
   logic [IDX_W-1:0]  r_rr_ptr;
   logic [IDX_W-1:0]  r_grant_idx;
   logic [BEAT_W-1:0] r_beat;

   logic [NUM_SRC-1:0]   w_req;
   logic [IDX_W-1:0]     w_pick;
   logic                 w_found;
   logic                 w_xfer;
   logic                 w_hs;
   logic                 w_last;
   logic [IDX_W-1:0]     w_next_ptr;
   logic [DATA_W-1:0]    w_src_data [NUM_SRC];
   logic [TBYTE_NUM-1:0] w_src_keep [NUM_SRC];

   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_slice
         assign w_src_data[gi] = axis.s_axis_tdata[gi*DATA_W +: DATA_W];
         assign w_src_keep[gi] = axis.s_axis_tkeep[gi*TBYTE_NUM +: TBYTE_NUM];
      end
   endgenerate

   assign w_req      = axis.s_axis_tvalid & src_mask;
   assign w_xfer     = (r_state == ST_XFER);
   assign w_hs       = w_xfer & axis.m_axis_tvalid & axis.m_axis_tready;
   assign w_last     = w_xfer & (r_beat == BEAT_W'(BURST_LEN - 1));
   assign w_next_ptr = (r_grant_idx == IDX_W'(NUM_SRC - 1)) ? '0 : r_grant_idx + 1'b1;

   util_rr_pick #(
      .NUM_SRC (NUM_SRC)
   ) u_pick (
      .i_req   (w_req),
      .i_ptr   (r_rr_ptr),
      .o_idx   (w_pick),
      .o_found (w_found)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_rr_ptr    <= '0;
         r_grant_idx <= '0;
         r_beat      <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (en && w_found) begin
                  r_grant_idx <= w_pick;
                  r_beat      <= '0;
                  r_state     <= ST_XFER;
               end
            end
            ST_XFER: begin
               // en and src_mask are not consulted here: a granted burst always runs to tlast.
               if (w_hs) begin
                  r_beat <= r_beat + 1'b1;
                  if (w_last) begin
                     r_rr_ptr <= w_next_ptr;
                     r_state  <= ST_IDLE;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      axis.s_axis_tready = '0;
      axis.m_axis_tvalid = 1'b0;
      axis.m_axis_tdata  = '0;
      axis.m_axis_tkeep  = '0;
      axis.m_axis_tid    = '0;
      if (w_xfer) begin
         axis.s_axis_tready[r_grant_idx] = axis.m_axis_tready;
         axis.m_axis_tvalid              = axis.s_axis_tvalid[r_grant_idx];
         axis.m_axis_tdata               = w_src_data[r_grant_idx];
         axis.m_axis_tkeep               = w_src_keep[r_grant_idx];
         axis.m_axis_tid                 = ID_WIDTH'(r_grant_idx);
      end
   end

   assign axis.m_axis_tlast = w_last;
   assign axis.m_axis_tdest = '0;
   assign busy              = w_xfer;
   assign grant_idx         = r_grant_idx;

`ifdef TRAFIC_ARB_STATS_EN
   logic [CNT_WIDTH-1:0] r_beat_cnt [NUM_SRC];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            r_beat_cnt[i] <= '0;
         end
      end else if (w_hs) begin
         r_beat_cnt[r_grant_idx] <= r_beat_cnt[r_grant_idx] + 1'b1;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_stat
         assign beat_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = r_beat_cnt[gi];
      end
   endgenerate
`else
   assign beat_cnt = '0;
`endif

endmodule
